sram_stream_reader: RTL and testbench



---
 rtl/sram_stream_reader_if.sv | 24 ++
 rtl/sram_stream_reader.sv | 155 +++++++++++++++
 tb/tb_sram_stream_reader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_reader_if.sv
// SRAM read port and output stream of the burst reader, bundled for port connection.
// master = reader side, slave = SRAM macro plus downstream consumer.
interface sram_stream_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic              sram_CEN;
    logic              sram_WEN;
    logic [ADDR_W-1:0] sram_A;
    logic [DATA_W-1:0] sram_Q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output sram_CEN, sram_WEN, sram_A, out_data, out_valid,
        input  sram_Q, out_ready
    );

    modport slave (
        input  sram_CEN, sram_WEN, sram_A, out_data, out_valid,
        output sram_Q, out_ready
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Burst read initiator for a single-port SRAM: sequential reads with one-cycle
// latency are buffered behind the output register and streamed out over valid/ready.
module sram_stream_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    sram_stream_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              cen_q, cen_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Entry 0 is the registered stream output; entries 1..2 form the skid buffer.
    logic [DATA_W-1:0] mem_q [3];
    logic [DATA_W-1:0] mem_d [3];
    logic [1:0]        count_q, count_d;
    logic              out_valid_q, out_valid_d;

    logic              pop;
    logic [1:0]        held_next;
    logic [1:0]        wr_idx;
    logic [2:0]        occ_sum;
    logic              room;

    assign pop       = out_valid_q & bus.out_ready;
    assign held_next = count_q + {1'b0, inflight_q} - {1'b0, pop};
    // A read decided now lands two cycles later; the one already on the bus
    // must be counted too, so every returned word is guaranteed a slot.
    assign occ_sum   = {1'b0, held_next} + {2'b00, ~cen_q};
    assign room      = (occ_sum < 3'd3);
    assign wr_idx    = count_q - {1'b0, pop};

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        mem_d[2] = mem_q[2];
        if (pop) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = mem_q[2];
        end
        if (inflight_q) begin
            case (wr_idx)
                2'd0:    mem_d[0] = bus.sram_Q;
                2'd1:    mem_d[1] = bus.sram_Q;
                2'd2:    mem_d[2] = bus.sram_Q;
                default: ;
            endcase
        end
        count_d     = held_next;
        out_valid_d = (held_next != 2'd0);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        cen_d       = 1'b1;
        a_d         = a_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        cen_d       = 1'b0;
                        a_d         = start_addr;
                        addr_d      = start_addr + ADDR_W'(1);
                        remaining_d = len - LEN_W'(1);
                        state_d     = (len == LEN_W'(1)) ? DRAIN : READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (remaining_q == '0) begin
                    state_d = DRAIN;
                end else if (room) begin
                    cen_d       = 1'b0;
                    a_d         = addr_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && cen_q && held_next == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        inflight_d = ~cen_q;
        busy_d     = (state_d == READ) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            cen_q       <= 1'b1;
            a_q         <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            mem_q[2]    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            cen_q       <= cen_d;
            a_q         <= a_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            mem_q[2]    <= mem_d[2];
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.sram_CEN  = cen_q;
    assign bus.sram_WEN  = 1'b1;
    assign bus.sram_A    = a_q;
    assign bus.out_data  = mem_q[0];
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: directed bursts against an SRAM model holding mem[i]=i*3,
// expected reads and words queued at stimulus time and consumed by a monitor.
module tb_sram_stream_reader;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] start_addr;
    logic [7:0] len;
    logic       busy;
    logic       done;

    sram_stream_reader_if #(.DATA_W(32), .ADDR_W(7)) bus ();

    sram_stream_reader #(.DATA_W(32), .ADDR_W(7), .LEN_W(8)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .bus        (bus.master)
    );

    always #5 CLK = ~CLK;

    logic [31:0] sram_mem [128];
    always @(posedge CLK) begin
        if (!bus.sram_CEN) bus.sram_Q <= sram_mem[bus.sram_A];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    int   exp_a [$];
    int   exp_d [$];
    int   start_cyc       = 0;
    int   first_cen_rel   = -1;
    int   first_valid_rel = -1;
    int   done_rel        = -1;
    int   done_seen       = 0;
    int   n_pops          = 0;
    int   ready_mode      = 0;
    logic held_prev       = 1'b0;
    int   held_data       = 0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            bus.out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        end
    end

    always @(negedge CLK) begin
        if (reset) begin
            held_prev = 1'b0;
        end else begin
            if (!bus.sram_CEN) begin
                if (first_cen_rel < 0) first_cen_rel = cyc - start_cyc;
                if (exp_a.size() == 0) chk("unexpected_read_addr", int'(bus.sram_A), -1);
                else chk("read_addr", int'(bus.sram_A), exp_a.pop_front());
            end
            if (bus.out_valid) begin
                if (first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
                if (held_prev) chk("held_data_stable", int'(bus.out_data), held_data);
                if (bus.out_ready) begin
                    n_pops++;
                    if (exp_d.size() == 0) chk("unexpected_word", int'(bus.out_data), -1);
                    else chk("out_data", int'(bus.out_data), exp_d.pop_front());
                end
            end
            held_prev = bus.out_valid && !bus.out_ready;
            held_data = int'(bus.out_data);
            if (done) begin
                done_seen++;
                done_rel = cyc - start_cyc;
            end
        end
    end

    task automatic issue_start(input int addr, input int n, input bit push_exp);
        if (push_exp) begin
            for (int i = 0; i < n; i++) begin
                exp_a.push_back((addr + i) % 128);
                exp_d.push_back(((addr + i) % 128) * 3);
            end
        end
        @(posedge CLK);
        #2;
        start      = 1'b1;
        start_addr = 7'(addr);
        len        = 8'(n);
        @(posedge CLK);
        #2;
        start = 1'b0;
    endtask

    task automatic prep_burst();
        @(posedge CLK);
        #2;
        first_cen_rel   = -1;
        first_valid_rel = -1;
        done_rel        = -1;
        done_seen       = 0;
        n_pops          = 0;
        start_cyc       = cyc + 1;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done_seen == 0 && t < 300) begin
            @(posedge CLK);
            t++;
        end
        if (done_seen == 0) chk({name, "_done_timeout"}, 0, 1);
        repeat (4) @(posedge CLK);
        chk({name, "_done_pulses"}, done_seen, 1);
        chk({name, "_reads_left"}, exp_a.size(), 0);
        chk({name, "_words_left"}, exp_d.size(), 0);
    endtask

    task automatic run_burst(input string name, input int addr, input int n, input int mode);
        ready_mode = mode;
        prep_burst();
        issue_start(addr, n, 1'b1);
        wait_done(name);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 128; i++) sram_mem[i] = 32'(i * 3);
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cen", int'(bus.sram_CEN), 1);
        chk("rst_wen", int'(bus.sram_WEN), 1);
        chk("rst_a", int'(bus.sram_A), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        #3 reset = 1'b0;

        run_burst("basic", 5, 4, 0);
        chk("basic_first_cen_cycle", first_cen_rel, 1);
        chk("basic_first_valid_cycle", first_valid_rel, 3);
        chk("basic_done_cycle", done_rel, 7);

        run_burst("wrap", 126, 4, 0);
        chk("wrap_wen_high", int'(bus.sram_WEN), 1);

        run_burst("backpressure", 60, 6, 1);
        chk("backpressure_pops", n_pops, 6);

        run_burst("len0", 33, 0, 0);
        chk("len0_done_cycle", done_rel, 1);
        chk("len0_no_read", first_cen_rel, -1);
        chk("len0_no_valid", first_valid_rel, -1);

        ready_mode = 0;
        prep_burst();
        issue_start(20, 6, 1'b1);
        @(posedge CLK);
        issue_start(90, 3, 1'b0);
        wait_done("ignored_start");
        chk("ignored_start_pops", n_pops, 6);

        ready_mode = 0;
        prep_burst();
        issue_start(10, 8, 1'b1);
        t = 0;
        while (n_pops < 2 && t < 100) begin
            @(posedge CLK);
            t++;
        end
        if (n_pops < 2) chk("abort_pop_timeout", n_pops, 2);
        @(negedge CLK);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cen", int'(bus.sram_CEN), 1);
        chk("abort_a", int'(bus.sram_A), 0);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_out_data", int'(bus.out_data), 0);
        exp_a.delete();
        exp_d.delete();
        repeat (2) @(posedge CLK);
        #2 reset = 1'b0;
        repeat (5) @(posedge CLK);
        chk("abort_no_done", done_seen, 0);

        run_burst("after_reset", 40, 3, 0);
        chk("after_reset_first_valid_cycle", first_valid_rel, 3);
        chk("after_reset_done_cycle", done_rel, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
